lfsr_cascade_counter: RTL and testbench
=======================================

Name: lfsr_cascade_counter

Overview:
- Parametrised successor to the fixed 6+58-bit LFSR/binary cascade counter.
- A Galois-LFSR prescaler of width LFSR_W produces a carry that advances a binary high counter of width HI_W.
- Adds the following, none of which the fixed version has:
  - sync clear and high-half load;
  - terminal-count output for further cascading;
  - sticky overflow flag;
  - snapshot register with valid/ready handshake.
- Sits between the event source (cnt) and the readout/bus interface.

Parameters:
- LFSR_W, 6, prescaler LFSR width (>=3).
- POLY, 6'h30, right-shift Galois tap mask; must give a maximal sequence.
- SEED, all-ones, LFSR reset/clear value; nonzero.
- HI_W, 58, binary high-counter width (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- cnt  in  1  count enable; one step per cycle when high.
- clr  in  1  sync clear.
- load  in  1  sync load of high counter.
- load_val  in  HI_W  value for load.
- count  out  LFSR_W+HI_W  {hi, lfsr} live state.
- tc  out  1  combinational terminal count.
- ovf  out  1  sticky overflow.
- snap_req  in  1  request snapshot.
- snap_data  out  LFSR_W+HI_W  captured count.
- snap_valid  out  1  snapshot held.
- snap_ready  in  1  consumer accepts snapshot.

Behaviour:
- Reset (nrst=0, async, any time including mid-count or mid-handshake):
  - lfsr=SEED, hi=0, ovf=0, snap_valid=0, snap_data=0.
  - Release is synchronous to the next clk edge.
- LFSR step:
  - lfsr_next = (lfsr>>1) ^ (lfsr[0] ? POLY : 0).
  - Period is 2^LFSR_W-1; the all-zero state is never entered.
- wrap = cnt && (lfsr_next == SEED).
- hi update:
  - On wrap, hi <= hi+1 mod 2^HI_W.
  - Otherwise hi holds.
- Full-count period = (2^LFSR_W-1)*2^HI_W enabled cycles.
- Overflow:
  - tc = wrap && (hi == all-ones). Combinational, same cycle as the final step.
  - ovf is set on the edge where tc=1 and hi goes to 0.
  - ovf stays set until clr or reset.
- Priority per cycle: clr > load > cnt.
  - clr: lfsr=SEED, hi=0, ovf=0. Snapshot path is unaffected.
  - load: hi=load_val, lfsr=SEED, ovf unchanged. cnt is ignored that cycle and tc=0.
  - cnt=0 with no clr/load: all state holds, tc=0.
- Snapshot handshake:
  - Capture happens when snap_req=1 and (snap_valid=0 or snap_ready=1).
  - On capture, snap_data <= count as seen in that cycle (pre-update value), and snap_valid=1 next cycle.
  - snap_valid=1 and snap_ready=1 with no snap_req: snap_valid <= 0.
  - snap_req while snap_valid=1 and snap_ready=0: ignored; snap_data stable.
  - Simultaneous accept+req: new capture, snap_valid stays 1, no bubble.
- snap_data/snap_valid are not modified by clr or load.
- Latency:
  - count reflects an update one cycle after the enabling edge.
  - Snapshot is visible one cycle after capture.

Test Plan:
- Default params, reset then cnt=1 for 2 cycles:
  - count[5:0] goes 3F -> 2F -> 27.
  - hi=0, ovf=0 throughout.
- LFSR_W=3, POLY=3'b110, SEED=7, HI_W=2, cnt=1 continuous:
  - lfsr sequence 7,5,4,2,1,6,3,7.
  - tc=0 at state 3 while hi<3.
  - hi increments on each return to 7.
  - At cycle 28: tc=1 in the cycle lfsr=3 with hi=3; next cycle hi=0, lfsr=7, ovf=1.
- Small config, cnt=1 with load=1 and load_val=2 in the same cycle:
  - Next: hi=2, lfsr=7.
  - Then clr=1 together with load=1: hi=0, lfsr=7, ovf=0 (clr wins).
- snap_req pulse while count={1,5}, snap_ready=0:
  - Next cycle snap_valid=1, snap_data={1,5}.
  - Further snap_req ignored while counting continues.
  - snap_ready=1 with no req: snap_valid=0.
- snap_valid=1, snap_ready=1 and snap_req=1 together:
  - snap_data updates to the current count.
  - snap_valid remains 1.
- Assert nrst=0 asynchronously mid-count with snap_valid=1:
  - Immediately lfsr=SEED, hi=0, ovf=0, snap_valid=0.
  - Counting resumes from SEED on the first edge after release.

Source files
------------

// File: rtl/lfsr_cascade_counter.sv
// rtl/lfsr_cascade_counter.sv - Galois-LFSR prescaler cascaded into a binary high counter with snapshot port
//
// Purpose:
//   A maximal-length Galois LFSR of width LFSR_W acts as a cheap prescaler. Each
//   time it returns to SEED it carries into a binary high counter of width HI_W.
//   The full count period is (2^LFSR_W-1)*2^HI_W enabled cycles.
//
// Ports:
//   clk         in   rising-edge clock
//   nrst        in   asynchronous active-low reset
//   cnt         in   count enable, one step per cycle
//   clr         in   sync clear of lfsr/hi/ovf (highest priority)
//   load        in   sync load of hi from load_val, lfsr back to SEED
//   load_val    in   [HI_W]            value for load
//   count       out  [LFSR_W+HI_W]     live {hi, lfsr}
//   tc          out  combinational terminal count (final step of full period)
//   ovf         out  sticky overflow, cleared by clr or reset
//   snap_req    in   request a snapshot of count
//   snap_data   out  [LFSR_W+HI_W]     captured count
//   snap_valid  out  snapshot held
//   snap_ready  in   consumer accepts the held snapshot

module lfsr_cascade_counter #(
    parameter int                LFSR_W = 6,
    parameter logic [LFSR_W-1:0] POLY   = 6'h30,
    parameter logic [LFSR_W-1:0] SEED   = {LFSR_W{1'b1}},
    parameter int                HI_W   = 58
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     cnt,
    input  logic                     clr,
    input  logic                     load,
    input  logic [HI_W-1:0]          load_val,
    output logic [LFSR_W+HI_W-1:0]   count,
    output logic                     tc,
    output logic                     ovf,
    input  logic                     snap_req,
    output logic [LFSR_W+HI_W-1:0]   snap_data,
    output logic                     snap_valid,
    input  logic                     snap_ready
);

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic [HI_W-1:0]   hi;
    logic              step_en;
    logic              wrap;
    logic              capture;

    // Right-shift Galois step: the bit shifted out selects the tap mask.
    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);

    // clr and load both pre-empt counting, so neither can produce a carry.
    assign step_en = cnt && !clr && !load;
    assign wrap    = step_en && (lfsr_next == SEED);
    assign tc      = wrap && (&hi);

    assign count   = {hi, lfsr};

    // A new snapshot may be taken when the slot is empty or being drained this cycle.
    assign capture = snap_req && (!snap_valid || snap_ready);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lfsr <= SEED;
            hi   <= '0;
            ovf  <= 1'b0;
        end else if (clr) begin
            lfsr <= SEED;
            hi   <= '0;
            ovf  <= 1'b0;
        end else if (load) begin
            lfsr <= SEED;
            hi   <= load_val;
        end else if (cnt) begin
            lfsr <= lfsr_next;
            if (wrap) begin
                hi <= hi + HI_W'(1);
            end
            if (tc) begin
                ovf <= 1'b1;
            end
        end
    end

    // Snapshot path is independent of clr/load.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            snap_data  <= '0;
            snap_valid <= 1'b0;
        end else if (capture) begin
            snap_data  <= count;
            snap_valid <= 1'b1;
        end else if (snap_ready) begin
            snap_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_cascade_counter.sv
// tb/tb_lfsr_cascade_counter.sv - directed self-checking bench for lfsr_cascade_counter

module tb_lfsr_cascade_counter;

    logic clk;
    logic nrst;

    // Default-parameter instance (6+58)
    logic        d_cnt, d_clr, d_load, d_snap_req, d_snap_ready;
    logic [57:0] d_load_val;
    logic [63:0] d_count, d_snap_data;
    logic        d_tc, d_ovf, d_snap_valid;

    // Small instance (3+2)
    logic        s_cnt, s_clr, s_load, s_snap_req, s_snap_ready;
    logic [1:0]  s_load_val;
    logic [4:0]  s_count, s_snap_data;
    logic        s_tc, s_ovf, s_snap_valid;

    int n_assert;
    int n_fail;

    lfsr_cascade_counter u_dut_def (
        .clk        (clk),
        .nrst       (nrst),
        .cnt        (d_cnt),
        .clr        (d_clr),
        .load       (d_load),
        .load_val   (d_load_val),
        .count      (d_count),
        .tc         (d_tc),
        .ovf        (d_ovf),
        .snap_req   (d_snap_req),
        .snap_data  (d_snap_data),
        .snap_valid (d_snap_valid),
        .snap_ready (d_snap_ready)
    );

    lfsr_cascade_counter #(
        .LFSR_W (3),
        .POLY   (3'b110),
        .SEED   (3'd7),
        .HI_W   (2)
    ) u_dut_small (
        .clk        (clk),
        .nrst       (nrst),
        .cnt        (s_cnt),
        .clr        (s_clr),
        .load       (s_load),
        .load_val   (s_load_val),
        .count      (s_count),
        .tc         (s_tc),
        .ovf        (s_ovf),
        .snap_req   (s_snap_req),
        .snap_data  (s_snap_data),
        .snap_valid (s_snap_valid),
        .snap_ready (s_snap_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected small-LFSR state after k steps from SEED
    logic [2:0] seq [7];

    initial begin
        seq[0] = 3'd7; seq[1] = 3'd5; seq[2] = 3'd4; seq[3] = 3'd2;
        seq[4] = 3'd1; seq[5] = 3'd6; seq[6] = 3'd3;

        n_assert = 0;
        n_fail   = 0;
        nrst = 1'b0;
        d_cnt = 0; d_clr = 0; d_load = 0; d_load_val = '0; d_snap_req = 0; d_snap_ready = 0;
        s_cnt = 0; s_clr = 0; s_load = 0; s_load_val = '0; s_snap_req = 0; s_snap_ready = 0;

        #12;
        check("rst_d_count", d_count, 64'h3F);
        check("rst_d_ovf", 64'(d_ovf), 64'd0);
        check("rst_d_snap_valid", 64'(d_snap_valid), 64'd0);
        check("rst_d_snap_data", d_snap_data, 64'd0);
        check("rst_s_count", 64'(s_count), 64'h07);
        @(negedge clk);
        nrst = 1'b1;

        // Default params: 3F -> 2F -> 27
        d_cnt = 1'b1;
        step();
        check("def_step1", d_count, 64'h2F);
        check("def_ovf1", 64'(d_ovf), 64'd0);
        step();
        check("def_step2", d_count, 64'h27);
        check("def_ovf2", 64'(d_ovf), 64'd0);
        d_cnt = 1'b0;
        step();
        check("def_hold", d_count, 64'h27);

        // Small config full period: 28 steps
        s_cnt = 1'b1;
        for (int k = 0; k < 28; k++) begin
            #1;
            check($sformatf("small_tc_k%0d", k), 64'(s_tc),
                  64'((k % 7 == 6) && (k / 7 == 3)));
            step();
            if (k < 27) begin
                check($sformatf("small_cnt_k%0d", k + 1), 64'(s_count),
                      64'({2'((k + 1) / 7), seq[(k + 1) % 7]}));
                check($sformatf("small_ovf_k%0d", k + 1), 64'(s_ovf), 64'd0);
            end
        end
        check("wrap_count", 64'(s_count), 64'({2'd0, 3'd7}));
        check("wrap_ovf", 64'(s_ovf), 64'd1);

        // load beats cnt; ovf unchanged
        s_load = 1'b1; s_load_val = 2'd2;
        #1;
        check("load_tc", 64'(s_tc), 64'd0);
        step();
        check("load_count", 64'(s_count), 64'({2'd2, 3'd7}));
        check("load_ovf", 64'(s_ovf), 64'd1);

        // clr beats load
        s_clr = 1'b1;
        step();
        check("clr_count", 64'(s_count), 64'({2'd0, 3'd7}));
        check("clr_ovf", 64'(s_ovf), 64'd0);
        s_clr = 1'b0; s_load = 1'b0;

        // Count 8 steps to reach {1,5}
        repeat (8) step();
        check("pre_snap_count", 64'(s_count), 64'({2'd1, 3'd5}));

        s_snap_req = 1'b1;
        step();
        check("snap1_valid", 64'(s_snap_valid), 64'd1);
        check("snap1_data", 64'(s_snap_data), 64'({2'd1, 3'd5}));
        check("snap1_count", 64'(s_count), 64'({2'd1, 3'd4}));

        step();
        check("snap_ignored_data", 64'(s_snap_data), 64'({2'd1, 3'd5}));
        check("snap_ignored_valid", 64'(s_snap_valid), 64'd1);
        check("snap_ignored_count", 64'(s_count), 64'({2'd1, 3'd2}));

        s_snap_req = 1'b0; s_snap_ready = 1'b1;
        step();
        check("drain_valid", 64'(s_snap_valid), 64'd0);
        check("drain_count", 64'(s_count), 64'({2'd1, 3'd1}));

        s_snap_req = 1'b1; s_snap_ready = 1'b0;
        step();
        check("snap2_data", 64'(s_snap_data), 64'({2'd1, 3'd1}));
        check("snap2_valid", 64'(s_snap_valid), 64'd1);

        s_snap_ready = 1'b1;
        step();
        check("accept_req_data", 64'(s_snap_data), 64'({2'd1, 3'd6}));
        check("accept_req_valid", 64'(s_snap_valid), 64'd1);
        check("accept_req_count", 64'(s_count), 64'({2'd1, 3'd3}));

        // Async reset mid-count with snapshot held
        s_snap_req = 1'b0; s_snap_ready = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        check("async_count", 64'(s_count), 64'({2'd0, 3'd7}));
        check("async_ovf", 64'(s_ovf), 64'd0);
        check("async_valid", 64'(s_snap_valid), 64'd0);
        check("async_data", 64'(s_snap_data), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        step();
        check("resume_count", 64'(s_count), 64'({2'd0, 3'd5}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
